// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 width codes,
// FSM states and latency limits.
package dmem_pkg;

   localparam logic [2:0] W_B  = 3'b000;
   localparam logic [2:0] W_H  = 3'b001;
   localparam logic [2:0] W_W  = 3'b010;
   localparam logic [2:0] W_BU = 3'b100;
   localparam logic [2:0] W_HU = 3'b101;

   localparam int unsigned LATENCY_MAX = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // True for the five funct3 codes the load/store port may issue.
   function automatic logic width_legal(input logic [2:0] i_width);
      return (i_width == W_B) || (i_width == W_H) || (i_width == W_W) ||
             (i_width == W_BU) || (i_width == W_HU);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and the core's
// right-aligned load/store data, for both the store and load paths.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  i_width,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wword,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   logic [31:0] w_shifted;

   // Store data is replicated across lanes so only the byte enables pick
   // the target lanes; load data is shifted down to bit 0 then extended.
   always_comb begin
      o_be       = '0;
      o_wword    = i_wdata;
      o_rdata    = '0;
      o_misalign = 1'b0;
      w_shifted  = i_rword >> {i_lane, 3'b000};
      case (i_width)
         W_B, W_BU: begin
            o_be    = 4'b0001 << i_lane;
            o_wword = {4{i_wdata[7:0]}};
            o_rdata = (i_width == W_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                       : {24'd0, w_shifted[7:0]};
         end
         W_H, W_HU: begin
            o_be       = 4'b0011 << i_lane;
            o_wword    = {2{i_wdata[15:0]}};
            o_rdata    = (i_width == W_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                          : {16'd0, w_shifted[15:0]};
            o_misalign = i_lane[0];
         end
         W_W: begin
            o_be       = 4'b1111;
            o_wword    = i_wdata;
            o_rdata    = i_rword;
            o_misalign = (i_lane != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready,
// committed to a byte-enabled word RAM after LATENCY cycles.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
   parameter int unsigned LATENCY   = 1,
   parameter string       INIT_FILE = ""
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_width,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [2:0]  r_width;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH];

   logic [31:0]   w_offset;
   logic          w_oor;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_rword;
   logic [3:0]    w_be;
   logic [31:0]   w_wword;
   logic [31:0]   w_rext;
   logic          w_misalign;
   logic          w_err;
   logic          w_commit;

   // Offset arithmetic wraps, so addresses below BASE_ADDR land out of range.
   assign w_offset = r_addr - BASE_ADDR;
   assign w_oor    = (w_offset >= 32'(4 * DEPTH));
   assign w_idx    = w_offset[AW+1:2];
   assign w_rword  = r_mem[w_idx];
   assign w_err    = w_misalign | w_oor | ~width_legal(r_width);
   assign w_commit = RST && (r_state == WAIT) && (r_cnt == 4'd0);

   dmem_lane_align u_align (
      .i_width    (r_width),
      .i_lane     (r_addr[1:0]),
      .i_wdata    (r_wdata),
      .i_rword    (w_rword),
      .o_be       (w_be),
      .o_wword    (w_wword),
      .o_rdata    (w_rext),
      .o_misalign (w_misalign)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = RST;
            if (req_valid) w_next = WAIT;
         end
         WAIT: if (r_cnt == 4'd0) w_next = RESP;
         RESP: begin
            resp_valid = RST;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Request latches, captured only on acceptance.
   always_ff @(posedge CLK) begin
      if (req_ready && req_valid) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_width <= req_width;
         r_wdata <= req_wdata;
      end
   end

   // Latency counter and registered response.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (req_ready && req_valid)             r_cnt <= 4'(LATENCY - 1);
         else if (r_state == WAIT && r_cnt != 0) r_cnt <= r_cnt - 4'd1;
         if (w_commit) begin
            r_rdata <= (w_err || r_we) ? '0 : w_rext;
            r_err   <= w_err;
         end
      end
   end

   // Byte-enabled RAM write; contents are never reset.
   always_ff @(posedge CLK) begin
      if (w_commit && r_we && !w_err) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
         end
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance 0 at LATENCY=1, instance 1 at 4, instance 2 at 3.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic [2:0]  rst_n, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr [3];
   logic [2:0]  req_width [3];
   logic [31:0] req_wdata [3];
   logic [31:0] resp_rdata [3];

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h2000), .LATENCY(1)) u_dut0 (
      .CLK(clk), .RST(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_width(req_width[0]),
      .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h2000), .LATENCY(4)) u_dut1 (
      .CLK(clk), .RST(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_width(req_width[1]),
      .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h2000), .LATENCY(3)) u_dut2 (
      .CLK(clk), .RST(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_width(req_width[2]),
      .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

   function automatic int lat_of(input int i);
      case (i)
         0:       return 1;
         1:       return 4;
         default: return 3;
      endcase
   endfunction

   // Full transaction: accept, count edges to resp_valid, check payload, consume.
   task automatic txn(input int i, input bit we, input logic [31:0] a, input logic [2:0] w,
                      input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e,
                      input string nm);
      int k;
      bit got;
      @(negedge clk);
      vecs++;
      if (req_ready[i] !== 1'b1) begin
         errs++; $display("FAIL %s req_ready: got %b expected 1", nm, req_ready[i]);
      end
      req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_width[i] = w; req_wdata[i] = wd;
      @(posedge clk); @(negedge clk);
      req_valid[i] = 1'b0;
      k = 0; got = 0;
      while (!got && k < 40) begin
         if (resp_valid[i] === 1'b1) got = 1;
         else begin @(posedge clk); @(negedge clk); k++; end
      end
      vecs++;
      if (!got || k != lat_of(i)) begin
         errs++; $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, k, got, lat_of(i));
      end
      vecs++;
      if (resp_rdata[i] !== exp_d) begin
         errs++; $display("FAIL %s rdata: got %h expected %h", nm, resp_rdata[i], exp_d);
      end
      vecs++;
      if (resp_err[i] !== exp_e) begin
         errs++; $display("FAIL %s err: got %b expected %b", nm, resp_err[i], exp_e);
      end
      resp_ready[i] = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready[i] = 1'b0;
      vecs++;
      if (resp_valid[i] !== 1'b0) begin
         errs++; $display("FAIL %s resp_valid after consume: got %b expected 0", nm, resp_valid[i]);
      end
   endtask

   task automatic test_reset();
      rst_n = 3'b000;
      @(negedge clk); @(posedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if (req_ready[i] !== 1'b0) begin errs++; $display("FAIL reset req_ready[%0d]: got %b expected 0", i, req_ready[i]); end
         vecs++;
         if (resp_valid[i] !== 1'b0) begin errs++; $display("FAIL reset resp_valid[%0d]: got %b expected 0", i, resp_valid[i]); end
         vecs++;
         if (resp_rdata[i] !== 32'h0) begin errs++; $display("FAIL reset rdata[%0d]: got %h expected 0", i, resp_rdata[i]); end
         vecs++;
         if (resp_err[i] !== 1'b0) begin errs++; $display("FAIL reset err[%0d]: got %b expected 0", i, resp_err[i]); end
      end
      rst_n = 3'b111;
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         vecs++;
         if (req_ready[i] !== 1'b1) begin errs++; $display("FAIL release req_ready[%0d]: got %b expected 1", i, req_ready[i]); end
      end
   endtask

   task automatic test_byte_store();
      txn(0, 1, 32'h2000, 3'b010, 32'hDEADBEEF, 32'h0, 0, "sw_2000");
      txn(0, 1, 32'h2001, 3'b000, 32'h00000080, 32'h0, 0, "sb_2001");
      txn(0, 0, 32'h2000, 3'b010, 32'h0, 32'hDEAD80EF, 0, "lw_after_sb");
   endtask

   task automatic test_load_ext();
      txn(0, 0, 32'h2001, 3'b000, 32'h0, 32'hFFFFFF80, 0, "lb_2001");
      txn(0, 0, 32'h2001, 3'b100, 32'h0, 32'h00000080, 0, "lbu_2001");
      txn(0, 0, 32'h2002, 3'b001, 32'h0, 32'hFFFFDEAD, 0, "lh_2002");
      txn(0, 0, 32'h2002, 3'b101, 32'h0, 32'h0000DEAD, 0, "lhu_2002");
      txn(0, 0, 32'h2003, 3'b000, 32'h0, 32'hFFFFFFDE, 0, "lb_2003");
   endtask

   task automatic test_errors();
      txn(0, 1, 32'h2001, 3'b001, 32'h0000FFFF, 32'h0, 1, "sh_misaligned");
      txn(0, 0, 32'h2000, 3'b010, 32'h0, 32'hDEAD80EF, 0, "lw_after_bad_sh");
      txn(0, 0, 32'h2002, 3'b010, 32'h0, 32'h0, 1, "lw_misaligned");
      txn(0, 0, 32'h1FFC, 3'b010, 32'h0, 32'h0, 1, "lw_below_base");
      txn(0, 0, 32'h3000, 3'b010, 32'h0, 32'h0, 1, "lw_past_end");
      txn(0, 1, 32'h2FFC, 3'b010, 32'hCAFEF00D, 32'h0, 0, "sw_last_word");
      txn(0, 0, 32'h2FFE, 3'b101, 32'h0, 32'h0000CAFE, 0, "lhu_last_word");
   endtask

   task automatic test_illegal_width();
      txn(0, 1, 32'h2000, 3'b011, 32'h00000000, 32'h0, 1, "store_w011");
      txn(0, 0, 32'h2000, 3'b110, 32'h0, 32'h0, 1, "load_w110");
      txn(0, 0, 32'h2000, 3'b010, 32'h0, 32'hDEAD80EF, 0, "lw_after_illegal");
   endtask

   task automatic test_backpressure();
      int k;
      bit got;
      txn(1, 1, 32'h2010, 3'b010, 32'h11223344, 32'h0, 0, "bp_sw");
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h2010; req_width[1] = 3'b010;
      @(posedge clk); @(negedge clk);
      // Second request queued while the first is outstanding.
      req_addr[1] = 32'h2010; req_width[1] = 3'b100;
      k = 0; got = 0;
      while (!got && k < 40) begin
         if (resp_valid[1] === 1'b1) got = 1;
         else begin @(posedge clk); @(negedge clk); k++; end
      end
      vecs++;
      if (!got || k != 4) begin errs++; $display("FAIL bp latency: got %0d expected 4", k); end
      for (int c = 0; c < 5; c++) begin
         vecs++;
         if (resp_valid[1] !== 1'b1) begin errs++; $display("FAIL bp hold%0d resp_valid: got %b expected 1", c, resp_valid[1]); end
         vecs++;
         if (resp_rdata[1] !== 32'h11223344) begin errs++; $display("FAIL bp hold%0d rdata: got %h expected 11223344", c, resp_rdata[1]); end
         vecs++;
         if (resp_err[1] !== 1'b0) begin errs++; $display("FAIL bp hold%0d err: got %b expected 0", c, resp_err[1]); end
         vecs++;
         if (req_ready[1] !== 1'b0) begin errs++; $display("FAIL bp hold%0d req_ready: got %b expected 0", c, req_ready[1]); end
         @(posedge clk); @(negedge clk);
      end
      resp_ready[1] = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready[1] = 1'b0;
      vecs++;
      if (resp_valid[1] !== 1'b0) begin errs++; $display("FAIL bp idle resp_valid: got %b expected 0", resp_valid[1]); end
      vecs++;
      if (req_ready[1] !== 1'b1) begin errs++; $display("FAIL bp idle req_ready: got %b expected 1", req_ready[1]); end
      @(posedge clk); @(negedge clk);
      req_valid[1] = 1'b0;
      vecs++;
      if (req_ready[1] !== 1'b0) begin errs++; $display("FAIL bp queued accept req_ready: got %b expected 0", req_ready[1]); end
      k = 0; got = 0;
      while (!got && k < 40) begin
         if (resp_valid[1] === 1'b1) got = 1;
         else begin @(posedge clk); @(negedge clk); k++; end
      end
      vecs++;
      if (!got || k != 4) begin errs++; $display("FAIL bp queued latency: got %0d expected 4", k); end
      vecs++;
      if (resp_rdata[1] !== 32'h00000044) begin errs++; $display("FAIL bp queued rdata: got %h expected 00000044", resp_rdata[1]); end
      resp_ready[1] = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      txn(2, 1, 32'h2004, 3'b010, 32'hA5A5A5A5, 32'h0, 0, "rm_prior_sw");
      @(negedge clk);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h2004;
      req_width[2] = 3'b010; req_wdata[2] = 32'h12345678;
      @(posedge clk); @(negedge clk);
      req_valid[2] = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n[2] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); @(negedge clk);
         vecs++;
         if (resp_valid[2] !== 1'b0) begin errs++; $display("FAIL rm cycle%0d resp_valid: got %b expected 0", c, resp_valid[2]); end
         vecs++;
         if (req_ready[2] !== 1'b0) begin errs++; $display("FAIL rm cycle%0d req_ready: got %b expected 0", c, req_ready[2]); end
      end
      rst_n[2] = 1'b1;
      @(posedge clk); @(negedge clk);
      vecs++;
      if (req_ready[2] !== 1'b1) begin errs++; $display("FAIL rm release req_ready: got %b expected 1", req_ready[2]); end
      vecs++;
      if (resp_valid[2] !== 1'b0) begin errs++; $display("FAIL rm release resp_valid: got %b expected 0", resp_valid[2]); end
      txn(2, 0, 32'h2004, 3'b010, 32'h0, 32'hA5A5A5A5, 0, "rm_lw_prior");
   endtask

   initial begin
      rst_n = 3'b000; req_valid = '0; req_we = '0; resp_ready = '0;
      for (int i = 0; i < 3; i++) begin
         req_addr[i] = '0; req_width[i] = '0; req_wdata[i] = '0;
      end
      test_reset();
      test_byte_store();
      test_load_ext();
      test_errors();
      test_illegal_width();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
